// File: rtl/wb_mem_responder_if.sv
// rtl/wb_mem_responder_if.sv - Pipelined Wishbone B4 bus bundle for the memory responder
interface wb_mem_responder_if;
    logic [63:0] adr;
    logic [63:0] dat_w;
    logic [63:0] dat_r;
    logic        we;
    logic [7:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        output adr, dat_w, we, sel, stb, cyc,
        input  dat_r, ack, stall, err
    );

    modport slave (
        input  adr, dat_w, we, sel, stb, cyc,
        output dat_r, ack, stall, err
    );
endinterface

// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - Pipelined Wishbone B4 responder over a 64-bit byte-writable RAM
module wb_mem_responder #(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    wb_mem_responder_if.slave wb
);
    localparam int         DEPTH    = 2 ** ADDR_BITS;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_bad_q;
    logic [63:0] pend_dat_q;
    logic        ack_q, err_q, stall_q;
    logic [63:0] dat_q;
    logic        ack_d, err_d, stall_d;
    logic [63:0] dat_d;

    logic [63:0]          mem [DEPTH];
    logic                 accept;
    logic                 bad_adr;
    logic [ADDR_BITS-1:0] idx;
    logic [63:0]          rd_word;
    logic [63:0]          resp_word;

    assign accept    = wb.cyc & wb.stb & ~stall_q;
    assign bad_adr   = (wb.adr[2:0] != 3'd0) | (wb.adr[63:ADDR_BITS+3] != '0);
    assign idx       = wb.adr[ADDR_BITS+2:3];
    assign rd_word   = mem[idx];
    // Read data is frozen at the accept edge; writes and errors complete with zero data.
    assign resp_word = (bad_adr | wb.we) ? 64'd0 : rd_word;

    always_ff @(posedge i_clk) begin
        if (accept && wb.we && !bad_adr) begin
            for (int k = 0; k < 8; k++) begin
                if (wb.sel[k]) begin
                    mem[idx][8*k +: 8] <= wb.dat_w[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            pend_bad_q <= 1'b0;
            pend_dat_q <= 64'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            stall_q    <= 1'b0;
            dat_q      <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            dat_q   <= dat_d;
            if (accept) begin
                pend_bad_q <= bad_adr;
                pend_dat_q <= resp_word;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        stall_d = 1'b0;
        dat_d   = 64'd0;
        if (WAIT_STATES == 0) begin
            state_d = IDLE;
            if (accept) begin
                ack_d = ~bad_adr;
                err_d = bad_adr;
                dat_d = resp_word;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                        stall_d = 1'b1;
                    end
                end
                WAIT: begin
                    // Dropping cyc abandons the request silently; a write stays committed.
                    if (!wb.cyc) begin
                        state_d = IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_d = RESP;
                        ack_d   = ~pend_bad_q;
                        err_d   = pend_bad_q;
                        dat_d   = pend_dat_q;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        stall_d = 1'b1;
                    end
                end
                RESP: begin
                    if (accept) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                        stall_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign wb.ack   = ack_q;
    assign wb.err   = err_q;
    assign wb.stall = stall_q;
    assign wb.dat_r = dat_q;
endmodule

// File: tb/tb_wb_mem_responder.sv
// tb/tb_wb_mem_responder.sv - Randomized scoreboard bench for wb_mem_responder at 0 and 3 wait states
module tb_wb_mem_responder;
    localparam int AB = 12;

    typedef struct {
        bit          cyc;
        bit          stb;
        logic [63:0] adr;
        bit          we;
        logic [7:0]  sel;
        logic [63:0] dat;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_mem_responder_if bus0 ();
    wb_mem_responder_if bus1 ();

    wb_mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .wb(bus0)
    );
    wb_mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(3)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .wb(bus1)
    );

    int          nvec = 0;
    int          nfail = 0;
    int          cyc_n = 0;
    int          wcfg [2] = '{0, 3};
    bit [63:0]   mmem [2][4096];
    bit          pend [2];
    int          left [2];
    bit          p_ack [2];
    bit [63:0]   p_dat [2];
    bit          e_ack [2], e_err [2], e_stall [2];
    bit [63:0]   e_dat [2];
    logic [63:0] last_dat [2];
    bit          rec = 1'b0;
    int          rec_d = 0;
    int          ackq[$];

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic req_t mk_idle();
        req_t r;
        r.cyc = 1'b0; r.stb = 1'b0; r.adr = 64'd0; r.we = 1'b0; r.sel = 8'd0; r.dat = 64'd0;
        return r;
    endfunction

    function automatic req_t rq(logic [63:0] a, bit we, logic [7:0] sel, logic [63:0] dat);
        req_t r;
        r.cyc = 1'b1; r.stb = 1'b1; r.adr = a; r.we = we; r.sel = sel; r.dat = dat;
        return r;
    endfunction

    function automatic logic [66:0] outs(int d);
        if (d == 0) return {bus0.ack, bus0.err, bus0.stall, bus0.dat_r};
        return {bus1.ack, bus1.err, bus1.stall, bus1.dat_r};
    endfunction

    task automatic drive(int d, req_t r);
        if (d == 0) begin
            bus0.cyc = r.cyc; bus0.stb = r.stb; bus0.adr = r.adr;
            bus0.we = r.we; bus0.sel = r.sel; bus0.dat_w = r.dat;
        end else begin
            bus1.cyc = r.cyc; bus1.stb = r.stb; bus1.adr = r.adr;
            bus1.we = r.we; bus1.sel = r.sel; bus1.dat_w = r.dat;
        end
    endtask

    // Reference: a request finishes W edges after its accept edge unless cyc drops meanwhile.
    task automatic model_step(int d, req_t r, output bit acc);
        bit bad;
        int idx;
        acc = 1'b0;
        e_ack[d] = 1'b0; e_err[d] = 1'b0; e_stall[d] = 1'b0; e_dat[d] = 64'd0;
        if (pend[d]) begin
            if (!r.cyc) begin
                pend[d] = 1'b0;
            end else begin
                left[d]--;
                if (left[d] == 0) begin
                    pend[d] = 1'b0;
                    e_ack[d] = p_ack[d];
                    e_err[d] = !p_ack[d];
                    e_dat[d] = p_dat[d];
                end else begin
                    e_stall[d] = 1'b1;
                end
            end
        end else if (r.cyc && r.stb) begin
            acc = 1'b1;
            bad = (r.adr % 8 != 0) || (r.adr >= (64'd1 << (AB + 3)));
            idx = int'(r.adr / 8) % 4096;
            p_dat[d] = 64'd0;
            p_ack[d] = !bad;
            if (!bad && r.we) begin
                for (int k = 0; k < 8; k++)
                    if (r.sel[k]) mmem[d][idx][8*k +: 8] = r.dat[8*k +: 8];
            end else if (!bad) begin
                p_dat[d] = mmem[d][idx];
            end
            if (wcfg[d] == 0) begin
                e_ack[d] = p_ack[d];
                e_err[d] = !p_ack[d];
                e_dat[d] = p_dat[d];
            end else begin
                pend[d] = 1'b1;
                left[d] = wcfg[d];
                e_stall[d] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [66:0] o;
        for (int d = 0; d < 2; d++) begin
            o = outs(d);
            check_eq($sformatf("d%0d_ack", d), 64'(o[66]), 64'(e_ack[d]));
            check_eq($sformatf("d%0d_err", d), 64'(o[65]), 64'(e_err[d]));
            check_eq($sformatf("d%0d_stall", d), 64'(o[64]), 64'(e_stall[d]));
            if (e_ack[d] || e_err[d]) check_eq($sformatf("d%0d_dat", d), o[63:0], e_dat[d]);
            if (o[66] === 1'b1) last_dat[d] = o[63:0];
            if (rec && rec_d == d && o[66] === 1'b1) ackq.push_back(cyc_n);
        end
    endtask

    task automatic run_cycle(int d, req_t r, output bit acc);
        bit a0, a1;
        @(negedge clk);
        cyc_n++;
        check_outputs();
        drive(0, d == 0 ? r : mk_idle());
        drive(1, d == 1 ? r : mk_idle());
        model_step(0, d == 0 ? r : mk_idle(), a0);
        model_step(1, d == 1 ? r : mk_idle(), a1);
        acc = (d == 0) ? a0 : a1;
    endtask

    task automatic send(int d, req_t r);
        bit acc;
        int n = 0;
        do begin
            run_cycle(d, r, acc);
            n++;
        end while (!acc && n < 40);
        if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(int d, bit c, int n);
        req_t r;
        bit a;
        r = mk_idle();
        r.cyc = c;
        r.stb = c ? 1'b0 : 1'($urandom_range(0, 1));
        r.adr = {$urandom, $urandom};
        for (int i = 0; i < n; i++) run_cycle(d, r, a);
    endtask

    task automatic reset_check();
        logic [66:0] o;
        for (int d = 0; d < 2; d++) begin
            o = outs(d);
            check_eq($sformatf("rst%0d_ack", d), 64'(o[66]), 64'd0);
            check_eq($sformatf("rst%0d_err", d), 64'(o[65]), 64'd0);
            check_eq($sformatf("rst%0d_stall", d), 64'(o[64]), 64'd0);
            check_eq($sformatf("rst%0d_dat", d), o[63:0], 64'd0);
        end
    endtask

    task automatic release_reset();
        bit a;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, mk_idle());
        drive(1, mk_idle());
        model_step(0, mk_idle(), a);
        model_step(1, mk_idle(), a);
    endtask

    function automatic logic [63:0] good_adr();
        int w = ($urandom_range(0, 9) == 0) ? 4095 : $urandom_range(0, 15);
        return 64'(w) << 3;
    endfunction

    function automatic logic [63:0] bad_adr();
        case ($urandom_range(0, 2))
            0:       return good_adr() | 64'($urandom_range(1, 7));
            1:       return good_adr() | (64'd1 << $urandom_range(AB + 3, 63));
            default: return {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        endcase
    endfunction

    function automatic logic [7:0] rand_sel();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic preload(int d);
        for (int w = 0; w < 17; w++)
            send(d, rq(64'(w == 16 ? 4095 : w) << 3, 1'b1, 8'hFF, {$urandom, $urandom}));
        idle(d, 1'b1, 5);
    endtask

    task automatic random_phase(int d, int n);
        for (int i = 0; i < n; i++) begin
            send(d, rq(($urandom_range(0, 4) == 0) ? bad_adr() : good_adr(),
                       1'($urandom_range(0, 1)), rand_sel(), {$urandom, $urandom}));
            if ($urandom_range(0, 2) == 0) idle(d, 1'($urandom_range(0, 3) != 0), $urandom_range(1, 4));
        end
        idle(d, 1'b1, 6);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout at cycle %0d", cyc_n);
        $fatal(1);
    end

    initial begin
        logic [63:0] dval;
        rst_n = 1'b1;
        drive(0, mk_idle());
        drive(1, mk_idle());
        #2 rst_n = 1'b0;
        #2 reset_check();
        release_reset();

        // Zero wait states
        preload(0);
        rec_d = 0; rec = 1'b1; ackq.delete();
        send(0, rq(64'h10, 1'b1, 8'hFF, 64'h1122334455667788));
        send(0, rq(64'h10, 1'b0, 8'h00, 64'd0));
        idle(0, 1'b1, 3);
        rec = 1'b0;
        check_eq("b2b_read", last_dat[0], 64'h1122334455667788);
        check_eq("b2b_ack_count", 64'(ackq.size()), 64'd2);
        if (ackq.size() == 2) check_eq("b2b_ack_spacing", 64'(ackq[1] - ackq[0]), 64'd1);

        send(0, rq(64'h18, 1'b1, 8'hFF, 64'h5555555555555555));
        send(0, rq(64'h18, 1'b1, 8'h0F, 64'hAAAAAAAAAAAAAAAA));
        send(0, rq(64'h18, 1'b0, 8'h00, 64'd0));
        idle(0, 1'b1, 2);
        check_eq("rmw_read", last_dat[0], 64'h55555555AAAAAAAA);

        send(0, rq(64'h4, 1'b1, 8'hFF, 64'hDEADBEEFDEADBEEF));
        send(0, rq(64'd1 << (AB + 3), 1'b1, 8'hFF, 64'hCAFEF00DCAFEF00D));
        send(0, rq(64'h18, 1'b1, 8'h00, 64'h0123456789ABCDEF));
        send(0, rq(64'h0, 1'b0, 8'hFF, 64'd0));
        send(0, rq(64'h18, 1'b0, 8'hFF, 64'd0));
        idle(0, 1'b1, 2);
        check_eq("sel0_unchanged", last_dat[0], 64'h55555555AAAAAAAA);
        random_phase(0, 200);

        // Three wait states
        preload(1);
        rec_d = 1; rec = 1'b1; ackq.delete();
        for (int w = 4; w < 8; w++) send(1, rq(64'(w) << 3, 1'b0, 8'h00, 64'd0));
        idle(1, 1'b1, 6);
        rec = 1'b0;
        check_eq("pipe_ack_count", 64'(ackq.size()), 64'd4);
        if (ackq.size() == 4)
            for (int i = 1; i < 4; i++) check_eq("pipe_ack_spacing", 64'(ackq[i] - ackq[i-1]), 64'd4);
        check_eq("pipe_last_data", last_dat[1], mmem[1][7]);

        send(1, rq(64'h4, 1'b1, 8'hFF, 64'hDEADBEEFDEADBEEF));
        send(1, rq(64'd1 << (AB + 3), 1'b0, 8'hFF, 64'd0));
        send(1, rq(64'h0, 1'b0, 8'hFF, 64'd0));
        idle(1, 1'b1, 5);

        dval = {$urandom, $urandom};
        send(1, rq(64'h28, 1'b1, 8'hFF, dval));
        idle(1, 1'b0, 3);
        send(1, rq(64'h28, 1'b0, 8'h00, 64'd0));
        idle(1, 1'b1, 5);
        check_eq("abort_commit", last_dat[1], dval);

        send(1, rq(64'h30, 1'b0, 8'h00, 64'd0));
        idle(1, 1'b1, 1);
        #2 rst_n = 1'b0;
        #1 reset_check();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        release_reset();
        send(1, rq(64'h30, 1'b0, 8'h00, 64'd0));
        idle(1, 1'b1, 5);
        check_eq("post_reset_read", last_dat[1], mmem[1][6]);

        random_phase(1, 150);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
